// File: rtl/rv32_pkg.sv
// Shared RV32 constants used by the fetch front end and by decode.
package rv32_pkg;

   localparam int unsigned RV_XLEN          = 32;
   localparam logic [31:0] RV_RESET_PC      = 32'h0000_0000;
   localparam int unsigned INSN_BYTES       = 4;
   localparam int unsigned FETCH_FIFO_DEPTH = 2;
   // addi x0, x0, 0: injected by decode on bubbles
   localparam logic [31:0] INSN_NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and same-cycle push/pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Flush wins over both push and pop
   assign w_push = i_push && !i_flush;
   assign w_pop  = i_pop && !i_flush && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches to a 1-cycle synchronous
// instruction memory and queues the returned words with their PC for decode.
module fetch_unit
   import rv32_pkg::*;
#(
   parameter int unsigned     XLEN       = RV_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RV_RESET_PC),
   parameter int unsigned     FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_ins
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_inflight_pc;
   logic              r_inflight;

   logic [CNT_W-1:0]  w_count;
   logic [CNT_W:0]    w_used;
   logic              w_empty;
   logic              w_req_fire;
   logic              w_pop;
   logic [XLEN-1:0]   w_redirect_pc;
   logic [2*XLEN-1:0] w_head;
   logic [1:0]        w_unused_redirect_lsb;

   assign w_redirect_pc         = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused_redirect_lsb = redirect_pc[1:0];

   assign out_valid = !w_empty && !redirect_valid;
   assign w_pop     = out_valid && out_ready;

   // A pop this cycle frees its slot before a word requested now can return,
   // which is what sustains one instruction per cycle with a 2-entry buffer.
   assign w_used     = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
   assign w_req_fire = !redirect_valid && (w_used < (CNT_W+1)'(FIFO_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= w_redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_req_fire;
         if (w_req_fire) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + XLEN'(INSN_BYTES);
         end
      end
   end

   // The fetch PC register drives the memory address directly
   assign imem_addr = r_fetch_pc;

   fetch_fifo #(
      .WIDTH(2 * XLEN),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (redirect_valid),
      .i_push  (r_inflight),
      .i_wdata ({r_inflight_pc, imem_rdata}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign out_pc  = w_head[2*XLEN-1:XLEN];
   assign out_ins = w_head[XLEN-1:0];

   a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
      imem_addr[1:0] == 2'b00);

endmodule
